// File: rtl/dkong_pkg.sv
// Shared constants for the Donkey Kong sprite/work RAM arbiter.
// Requester indices select bits in the request, grant and ack vectors.
package dkong_pkg;

  localparam int REQ_DMA = 0;
  localparam int REQ_CPU = 1;
  localparam int REQ_HS  = 2;
  localparam int NUM_REQ = 3;

  localparam int RAM_AW = 10;
  localparam int RAM_DW = 8;

endpackage

// File: rtl/dkong_prio_arb3.sv
// Combinational three-way fixed-priority picker with a one-hot grant.
// Order: promoted HS, then DMA, then CPU, then HS.
module dkong_prio_arb3
  import dkong_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               promote,
  output logic [NUM_REQ-1:0] grant
);

  // Pick at most one winner from the eligible requests
  always_comb begin
    grant = '0;
    if (promote && req[REQ_HS]) begin
      grant[REQ_HS] = 1'b1;
    end else if (req[REQ_DMA]) begin
      grant[REQ_DMA] = 1'b1;
    end else if (req[REQ_CPU]) begin
      grant[REQ_CPU] = 1'b1;
    end else if (req[REQ_HS]) begin
      grant[REQ_HS] = 1'b1;
    end
  end

endmodule

// File: rtl/dkong_ram_arb.sv
// Single-port arbiter for the 1 KB sprite/work RAM shared by the Z80,
// the sprite DMA reader and the high-score load/save port.
// Optional: define DKONG_RAM_ARB_STATS_EN to add O_CPU_STALL_CNT, a
// saturating count of cycles the Z80 spends with WAIT_n low.
module dkong_ram_arb
  import dkong_pkg::*;
#(
  parameter int AW     = RAM_AW,
  parameter int DW     = RAM_DW,
  parameter int HS_MAX = 8
)
(
  input  logic          I_CLK,
  input  logic          I_RESET_n,
  input  logic          I_CPU_REQ,
  input  logic          I_CPU_WE,
  input  logic [AW-1:0] I_CPU_A,
  input  logic [DW-1:0] I_CPU_D,
  output logic          O_CPU_ACK,
  output logic [DW-1:0] O_CPU_Q,
  output logic          O_CPU_WAIT_n,
  input  logic          I_DMA_REQ,
  input  logic [AW-1:0] I_DMA_A,
  output logic          O_DMA_ACK,
  output logic [DW-1:0] O_DMA_Q,
  input  logic          I_HS_REQ,
  input  logic          I_HS_WE,
  input  logic [AW-1:0] I_HS_A,
  input  logic [DW-1:0] I_HS_D,
  output logic          O_HS_ACK,
  output logic [DW-1:0] O_HS_Q,
  output logic [AW-1:0] O_RAM_A,
  output logic [DW-1:0] O_RAM_D,
  output logic          O_RAM_CE,
  output logic          O_RAM_WE,
  input  logic [DW-1:0] I_RAM_Q
`ifdef DKONG_RAM_ARB_STATS_EN
  ,
  output logic [15:0]   O_CPU_STALL_CNT
`endif
);

  // Handshake: a requester raises REQ with A/D/WE stable and holds them
  // until its ACK. A grant in cycle N drives the RAM port in cycle N; ACK
  // pulses for one cycle in N+1 with the RAM read data on Q (Q is 0 at all
  // other times). In the ACK cycle the requester drops REQ or presents a
  // new access; the ack register doubles as the in-flight mask so a held
  // REQ is not granted twice.

  localparam logic [7:0] HS_MAX_C = HS_MAX[7:0];

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] ack_r;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant_raw;
  logic [NUM_REQ-1:0] grant;
  logic [7:0]         hs_cnt;
  logic               promote;

  assign req_vec[REQ_DMA] = I_DMA_REQ;
  assign req_vec[REQ_CPU] = I_CPU_REQ;
  assign req_vec[REQ_HS]  = I_HS_REQ;

  assign elig    = req_vec & ~ack_r;
  assign promote = (hs_cnt == HS_MAX_C);

  dkong_prio_arb3 u_prio (
    .req     (elig),
    .promote (promote),
    .grant   (grant_raw)
  );

  // Reset also blanks the grant so the RAM port goes idle immediately
  assign grant = grant_raw & {NUM_REQ{I_RESET_n}};

  // Drive the RAM port from the winner of this cycle; idle port is all zero
  always_comb begin
    O_RAM_A  = '0;
    O_RAM_D  = '0;
    O_RAM_CE = 1'b0;
    O_RAM_WE = 1'b0;
    if (grant[REQ_DMA]) begin
      O_RAM_A  = I_DMA_A;
      O_RAM_CE = 1'b1;
    end else if (grant[REQ_CPU]) begin
      O_RAM_A  = I_CPU_A;
      O_RAM_D  = I_CPU_D;
      O_RAM_CE = 1'b1;
      O_RAM_WE = I_CPU_WE;
    end else if (grant[REQ_HS]) begin
      O_RAM_A  = I_HS_A;
      O_RAM_D  = I_HS_D;
      O_RAM_CE = 1'b1;
      O_RAM_WE = I_HS_WE;
    end
  end

  // Register the grant: one-cycle ACK and in-flight mask for next cycle
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      ack_r <= '0;
    end else begin
      ack_r <= grant;
    end
  end

  // HS starvation counter: counts lost cycles, clears on grant or idle
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      hs_cnt <= '0;
    end else if (!I_HS_REQ || grant[REQ_HS]) begin
      hs_cnt <= '0;
    end else if (elig[REQ_HS] && hs_cnt != HS_MAX_C) begin
      hs_cnt <= hs_cnt + 8'd1;
    end
  end

  assign O_DMA_ACK = ack_r[REQ_DMA];
  assign O_CPU_ACK = ack_r[REQ_CPU];
  assign O_HS_ACK  = ack_r[REQ_HS];

  assign O_DMA_Q = ack_r[REQ_DMA] ? I_RAM_Q : '0;
  assign O_CPU_Q = ack_r[REQ_CPU] ? I_RAM_Q : '0;
  assign O_HS_Q  = ack_r[REQ_HS]  ? I_RAM_Q : '0;

  assign O_CPU_WAIT_n = ~(I_CPU_REQ & ~ack_r[REQ_CPU]);

`ifdef DKONG_RAM_ARB_STATS_EN
  logic [15:0] stall_cnt;

  // Count Z80 wait cycles, sticking at all-ones
  always_ff @(posedge I_CLK or negedge I_RESET_n) begin
    if (!I_RESET_n) begin
      stall_cnt <= '0;
    end else if (!O_CPU_WAIT_n && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign O_CPU_STALL_CNT = stall_cnt;
`endif

endmodule

// File: doc/dkong_ram_arb.md
Name: dkong_ram_arb

Overview:
- Single-port arbiter for the 1 KB sprite/work RAM. The RAM is shared by three requesters: the main Z80, the sprite DMA reader and the high-score load/save port.
- It replaces ad-hoc muxing of these three paths with one registered grant pipeline.
- It sits between the address decoder/DMA/hiscore logic and one 1024x8 synchronous RAM port.

Parameters:
- AW, 10, RAM address width.
- DW, 8, RAM data width.
- HS_MAX, 8, number of consecutive lost arbitration cycles after which the hiscore port is promoted to top priority (1..255).

Ports:
- I_CLK  in  1  24.576 MHz system clock
- I_RESET_n  in  1  asynchronous, active-low reset
- I_CPU_REQ  in  1  CPU access request, held until O_CPU_ACK
- I_CPU_WE  in  1  1 = write
- I_CPU_A  in  AW  CPU address
- I_CPU_D  in  DW  CPU write data
- O_CPU_ACK  out  1  one-cycle completion pulse
- O_CPU_Q  out  DW  read data; valid with ACK, 0 otherwise
- O_CPU_WAIT_n  out  1  Z80 wait; low while the CPU request is outstanding
- I_DMA_REQ  in  1  DMA read request
- I_DMA_A  in  AW  DMA address
- O_DMA_ACK  out  1  completion pulse
- O_DMA_Q  out  DW  read data; valid with ACK, 0 otherwise
- I_HS_REQ  in  1  hiscore request
- I_HS_WE  in  1  hiscore write
- I_HS_A  in  AW  hiscore address
- I_HS_D  in  DW  hiscore write data
- O_HS_ACK  out  1  completion pulse
- O_HS_Q  out  DW  read data; valid with ACK, 0 otherwise
- O_RAM_A  out  AW  RAM address
- O_RAM_D  out  DW  RAM write data
- O_RAM_CE  out  1  RAM enable
- O_RAM_WE  out  1  RAM write enable
- I_RAM_Q  in  DW  RAM read data, one clock after the CE cycle

Behaviour:
- Clocking: one clock, I_CLK. Reset is asynchronous, active-low, on I_RESET_n.
- Reset values: all ACKs 0, in-flight flags 0, HS starvation counter 0, O_RAM_CE 0, O_RAM_WE 0.
- Eligibility: each cycle, requester X is eligible when REQ_X=1 and X was not granted in the previous cycle (in-flight mask). The mask stops a held request from being granted twice.
- Priority: HS if promoted, then DMA, then CPU, then HS.
  - At most one grant per cycle.
  - Arbitration is combinational from the eligible requests.
- Granted cycle N: O_RAM_CE=1, and O_RAM_A/O_RAM_D/O_RAM_WE are driven from the winner (WE forced 0 for DMA).
  - No grant: CE=0, WE=0, A and D = 0.
- Cycle N+1: registered ACK_X=1 for exactly one cycle.
  - O_X_Q = I_RAM_Q during that cycle, 0 otherwise (OR-bus convention).
  - Write ACKs also return I_RAM_Q; requesters ignore it.
- Requester rules:
  - Drops REQ, or presents a new access, in the ACK cycle.
  - Holds A/D/WE stable from REQ rise until ACK.
- Throughput: a lone requester gets one access per 2 cycles. Two alternating requesters fill every cycle.
- O_CPU_WAIT_n = ~(I_CPU_REQ & ~O_CPU_ACK). This is combinational, so the minimum CPU stall is one clock.
- HS starvation counter:
  - Increments each cycle HS is eligible but not granted.
  - Clears on an HS grant or when I_HS_REQ=0.
  - Saturates at HS_MAX.
  - At count==HS_MAX, HS is promoted for the next grant only; the counter clears on that grant.
- Simultaneous events:
  - DMA and CPU both eligible: DMA wins, CPU retries next cycle.
  - CPU becomes ineligible (in-flight) the cycle after its own grant. HS or DMA may use that cycle.
- Request withdrawn before grant: no access, no ACK.
- Reset asserted mid-access: the pending ACK is discarded and outputs return to reset values immediately.

Optional Feature:
- Macro: DKONG_RAM_ARB_STATS_EN.
- Defined: adds output O_CPU_STALL_CNT[15:0], a saturating count of cycles with O_CPU_WAIT_n=0.
  - Resets to 0.
  - Holds at 16'hFFFF when saturated.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package dkong_pkg holds:
  - requester index constants REQ_DMA=0, REQ_CPU=1, REQ_HS=2
  - RAM_AW=10, RAM_DW=8
- One sub-module is natural: dkong_prio_arb3, a combinational 3-input fixed-priority picker with a promote input, returning a one-hot grant.
- Pipeline registers, masks and counters stay in the top module.

Test Plan:
- CPU-only read:
  - Stimulus: CPU_REQ=1, A=10'h155 at cycle 0, RAM holds 8'hA5 at 10'h155.
  - Expected: RAM_CE=1 at cycle 0, CPU_ACK=1 and CPU_Q=8'hA5 at cycle 1, WAIT_n low in cycle 0 only.
- DMA vs CPU collision:
  - Stimulus: both request in the same cycle.
  - Expected: DMA granted cycle 0 (ACK cycle 1), CPU granted cycle 1 (ACK cycle 2), CPU WAIT_n low cycles 0-1.
- HS starvation:
  - Stimulus: HS_MAX=4; CPU and DMA request continuously, each re-requesting immediately after its ACK; HS requests continuously.
  - Expected: HS granted no later than the 5th cycle after HS_REQ rises; counter back to 0 after the grant.
- HS write then CPU read-back:
  - Stimulus: HS writes 8'h3C to 10'h3FF, then CPU reads 10'h3FF.
  - Expected: CPU_Q=8'h3C; DMA request with WE pattern leaves RAM_WE=0.
- Reset mid-access:
  - Stimulus: I_RESET_n low in the grant cycle.
  - Expected: no ACK pulse; CE/WE=0 asynchronously; first post-reset request is served normally.
- STATS_EN:
  - Stimulus: 3 colliding CPU accesses.
  - Expected: O_CPU_STALL_CNT equals the counted WAIT_n-low cycles (here 6); forced 16'hFFFE advances to 16'hFFFF and holds.
